ps2_packet_framer: RTL and testbench

Parametrised PS/2-style packet framer for the sequential-FSM problem set. It consumes a stream of bytes with a valid qualifier and hunts for a sync byte (bit SYNC_BIT set). It assembles NBYTES-byte messages, pulses `done` with the completed message on `out_`, and counts discarded bytes. An optional idle timeout abandons partial messages. It sits between a byte-level receiver and message-level consumers.

---
 rtl/ps2_pkg.sv | 10 +
 rtl/ps2_idle_timer.sv | 32 +++
 rtl/ps2_packet_framer.sv | 141 ++++++++++++++
 tb/tb_ps2_packet_framer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and default constants for the PS/2 packet framer.
package ps2_pkg;

  // Framer is either hunting for a first byte or filling a message.
  typedef enum logic [0:0] {SEARCH, COLLECT} state_t;

  localparam int PS2_NBYTES   = 3;
  localparam int PS2_SYNC_BIT = 3;

endpackage

// File: rtl/ps2_idle_timer.sv
// Idle counter for a partially assembled message. Counts idle ticks
// while a message is open and flags when the allowed idle budget is
// used up. A TIMEOUT of 0 disables expiry entirely.
module ps2_idle_timer #(
  parameter int TIMEOUT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST = (TIMEOUT > 1) ? TW'(TIMEOUT - 1) : '0;

  logic [TW-1:0] count;

  // Count idle ticks, holding at the last value so the counter cannot wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick && count != LAST) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (TIMEOUT != 0) && tick && (count == LAST);

endmodule

// File: rtl/ps2_packet_framer.sv
// Byte-stream to message framer. Hunts for a byte with the sync bit set,
// gathers NBYTES bytes into a message, publishes it on out_ with a done
// pulse, and counts bytes thrown away while hunting. Partial messages
// that go idle too long are abandoned with an abort pulse.
module ps2_packet_framer
  import ps2_pkg::*;
#(
  parameter int NBYTES   = PS2_NBYTES,
  parameter int SYNC_BIT = PS2_SYNC_BIT,
  parameter int TIMEOUT  = 0,
  parameter int CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_,
  output logic                  done,
  output logic [8*NBYTES-1:0]   out_,
  output logic                  abort,
  output logic [CNT_W-1:0]      drop_count
);

  localparam int IDX_W = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t               state;
  state_t               next_state;
  logic [IDX_W-1:0]     idx;
  logic [7:0]           buffer [NBYTES];
  logic [8*NBYTES-1:0]  message;
  logic                 take_first;
  logic                 take_next;
  logic                 finish;
  logic                 drop;
  logic                 expire;
  logic                 timeout_abort;
  logic                 idle_clear;
  logic                 idle_tick;

  assign idle_tick  = (state == COLLECT) && !in_valid;
  assign idle_clear = (state != COLLECT) || in_valid;

  ps2_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (idle_clear),
    .tick   (idle_tick),
    .expire (expire)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SEARCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and per-cycle control decisions.
  always_comb begin
    next_state    = state;
    take_first    = 1'b0;
    take_next     = 1'b0;
    finish        = 1'b0;
    drop          = 1'b0;
    timeout_abort = 1'b0;
    case (state)
      SEARCH: begin
        if (in_valid) begin
          if (in_[SYNC_BIT]) begin
            take_first = 1'b1;
            next_state = COLLECT;
          end else begin
            drop = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (in_valid) begin
          take_next = 1'b1;
          if (idx == LAST_IDX) begin
            finish     = 1'b1;
            next_state = SEARCH;
          end
        end else if (expire) begin
          timeout_abort = 1'b1;
          next_state    = SEARCH;
        end
      end
      default: next_state = SEARCH;
    endcase
  end

  // Completed message: stored bytes first, the byte arriving now last.
  always_comb begin
    message = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (i == NBYTES - 1) begin
        message[8*(NBYTES-i)-1 -: 8] = in_;
      end else begin
        message[8*(NBYTES-i)-1 -: 8] = buffer[i];
      end
    end
  end

  // Byte assembly, registered outputs and the saturating drop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= '0;
      out_       <= '0;
      done       <= 1'b0;
      abort      <= 1'b0;
      drop_count <= '0;
      for (int i = 0; i < NBYTES; i++) begin
        buffer[i] <= '0;
      end
    end else begin
      done  <= finish;
      abort <= timeout_abort;
      if (take_first) begin
        buffer[0] <= in_;
        idx       <= IDX_W'(1);
      end else if (take_next) begin
        buffer[idx] <= in_;
        idx         <= finish ? '0 : idx + 1'b1;
      end else if (timeout_abort) begin
        idx <= '0;
      end
      if (finish) begin
        out_ <= message;
      end
      if (drop && drop_count != '1) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_packet_framer.sv
// Self-checking bench for ps2_packet_framer: a hand-built vector table,
// a randomized run against a queue-based message model, and an
// asynchronous reset / counter saturation sequence.
module tb_ps2_packet_framer;

  localparam int NB = 3;
  localparam int SB = 3;
  localparam int TO = 4;
  localparam int CW = 8;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic [7:0]      in_;
  logic            done;
  logic [8*NB-1:0] out_;
  logic            abort;
  logic [CW-1:0]   drop_count;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic            v;
    logic [7:0]      b;
    logic            done;
    logic            abort;
    logic [8*NB-1:0] out;
    logic [CW-1:0]   drop;
  } vec_t;

  vec_t vecs[$];

  logic [7:0]      m_partial[$];
  int              m_idle;
  logic [8*NB-1:0] m_out;
  int              m_drop;
  logic            m_done;
  logic            m_abort;

  ps2_packet_framer #(
    .NBYTES   (NB),
    .SYNC_BIT (SB),
    .TIMEOUT  (TO),
    .CNT_W    (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_        (in_),
    .done       (done),
    .out_       (out_),
    .abort      (abort),
    .drop_count (drop_count)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of input and sample just after the edge that takes it.
  task applyStimulus(input logic v, input logic [7:0] b);
    @(negedge clk);
    in_valid = v;
    in_      = b;
    @(posedge clk);
    #1;
  endtask

  task checkOutput(input string name, input logic ed, input logic ea,
                   input logic [8*NB-1:0] eo, input logic [CW-1:0] edr);
    checks++;
    if (done !== ed || abort !== ea || out_ !== eo || drop_count !== edr) begin
      $display("[TB] FAIL %s: got done=%0b abort=%0b out_=%h drop=%0d, want done=%0b abort=%0b out_=%h drop=%0d",
               name, done, abort, out_, drop_count, ed, ea, eo, edr);
    end else begin
      passes++;
    end
  endtask

  task doReset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    in_      = 8'h00;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task addVec(input logic v, input logic [7:0] b, input logic d, input logic a,
              input logic [8*NB-1:0] o, input logic [CW-1:0] dr);
    vec_t t;
    t.v = v; t.b = b; t.done = d; t.abort = a; t.out = o; t.drop = dr;
    vecs.push_back(t);
  endtask

  task modelReset();
    m_partial.delete();
    m_idle  = 0;
    m_out   = '0;
    m_drop  = 0;
    m_done  = 1'b0;
    m_abort = 1'b0;
  endtask

  // Message-level reference: a queue holds the bytes of the open message.
  task modelStep(input logic v, input logic [7:0] b);
    m_done  = 1'b0;
    m_abort = 1'b0;
    if (m_partial.size() == 0) begin
      if (v) begin
        if (b[SB]) begin
          m_partial.push_back(b);
          m_idle = 0;
        end else if (m_drop < (1 << CW) - 1) begin
          m_drop++;
        end
      end
    end else if (v) begin
      m_partial.push_back(b);
      m_idle = 0;
      if (m_partial.size() == NB) begin
        m_out = '0;
        foreach (m_partial[i]) m_out = (m_out << 8) | (8*NB)'(m_partial[i]);
        m_done = 1'b1;
        m_partial.delete();
      end
    end else begin
      m_idle++;
      if (TO != 0 && m_idle == TO) begin
        m_abort = 1'b1;
        m_partial.delete();
      end
    end
  endtask

  initial begin
    logic       rv;
    logic [7:0] rb;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_      = 8'h00;
    #1;
    checkOutput("reset state", 1'b0, 1'b0, 24'h0, 8'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single message straight after reset.
    addVec(1, 8'h08, 0, 0, 24'h000000, 0);
    addVec(1, 8'h11, 0, 0, 24'h000000, 0);
    addVec(1, 8'h22, 1, 0, 24'h081122, 0);
    // Two discarded bytes before a message.
    addVec(1, 8'h00, 0, 0, 24'h081122, 1);
    addVec(1, 8'h01, 0, 0, 24'h081122, 2);
    addVec(1, 8'h08, 0, 0, 24'h081122, 2);
    addVec(1, 8'h55, 0, 0, 24'h081122, 2);
    addVec(1, 8'h66, 1, 0, 24'h085566, 2);
    // Back-to-back messages, sync bit ignored after the first byte.
    addVec(1, 8'h0F, 0, 0, 24'h085566, 2);
    addVec(1, 8'hAA, 0, 0, 24'h085566, 2);
    addVec(1, 8'hBB, 1, 0, 24'h0FAABB, 2);
    addVec(1, 8'h38, 0, 0, 24'h0FAABB, 2);
    addVec(1, 8'hCC, 0, 0, 24'h0FAABB, 2);
    addVec(1, 8'hDD, 1, 0, 24'h38CCDD, 2);
    // A sync byte without in_valid must not open a message.
    addVec(0, 8'h08, 0, 0, 24'h38CCDD, 2);
    addVec(1, 8'h11, 0, 0, 24'h38CCDD, 3);
    // Timeout after four idle cycles, then a fresh message.
    addVec(1, 8'h08, 0, 0, 24'h38CCDD, 3);
    addVec(1, 8'h11, 0, 0, 24'h38CCDD, 3);
    addVec(0, 8'h00, 0, 0, 24'h38CCDD, 3);
    addVec(0, 8'h00, 0, 0, 24'h38CCDD, 3);
    addVec(0, 8'h00, 0, 0, 24'h38CCDD, 3);
    addVec(0, 8'h00, 0, 1, 24'h38CCDD, 3);
    addVec(0, 8'h00, 0, 0, 24'h38CCDD, 3);
    addVec(1, 8'h08, 0, 0, 24'h38CCDD, 3);
    addVec(1, 8'h01, 0, 0, 24'h38CCDD, 3);
    addVec(1, 8'h02, 1, 0, 24'h080102, 3);
    // Byte arriving in the slot where the timer would expire wins.
    addVec(1, 8'h08, 0, 0, 24'h080102, 3);
    addVec(1, 8'h11, 0, 0, 24'h080102, 3);
    addVec(0, 8'h00, 0, 0, 24'h080102, 3);
    addVec(0, 8'h00, 0, 0, 24'h080102, 3);
    addVec(0, 8'h00, 0, 0, 24'h080102, 3);
    addVec(1, 8'h22, 1, 0, 24'h081122, 3);
    addVec(0, 8'h00, 0, 0, 24'h081122, 3);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].v, vecs[i].b);
      checkOutput($sformatf("vec%0d", i), vecs[i].done, vecs[i].abort,
                  vecs[i].out, vecs[i].drop);
    end

    // Randomized run against the message model.
    doReset();
    modelReset();
    checkOutput("random reset", 1'b0, 1'b0, 24'h0, 8'd0);
    for (int i = 0; i < 2000; i++) begin
      rv = ($urandom_range(0, 9) < 6);
      rb = 8'($urandom);
      applyStimulus(rv, rb);
      modelStep(rv, rb);
      checkOutput($sformatf("rand%0d", i), m_done, m_abort, m_out, CW'(m_drop));
    end

    // Asynchronous reset in the middle of a message.
    doReset();
    applyStimulus(1, 8'h08);
    applyStimulus(1, 8'h11);
    applyStimulus(1, 8'h22);
    checkOutput("pre-reset msg", 1'b1, 1'b0, 24'h081122, 8'd0);
    applyStimulus(1, 8'h08);
    applyStimulus(1, 8'h11);
    #2;
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    checkOutput("async reset", 1'b0, 1'b0, 24'h0, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1, 8'h33);
    checkOutput("post-reset 33", 1'b0, 1'b0, 24'h0, 8'd1);
    applyStimulus(1, 8'h44);
    checkOutput("post-reset 44", 1'b0, 1'b0, 24'h0, 8'd2);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1, 8'($urandom) & 8'hF7);
      if (i == 250) checkOutput("drop 253", 1'b0, 1'b0, 24'h0, 8'd253);
      if (i == 251) checkOutput("drop 254", 1'b0, 1'b0, 24'h0, 8'd254);
    end
    checkOutput("drop saturated", 1'b0, 1'b0, 24'h0, 8'hFF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
